apb_cmd_master: RTL and testbench

- Upstream APB requester that feeds the ALU register slave.
- Accepts single register read/write commands on a valid/ready interface and converts each into one APB transfer: SETUP, then ACCESS held until pready.
- Returns one response per command: read data, plus an error flag when the timeout feature is enabled.
- Issues one transfer at a time; there is no command queueing.

---
 rtl/apb_pkg.sv | 26 ++
 rtl/apb_cmd_master.sv | 162 ++++++++++++++++
 tb/tb_apb_cmd_master.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : apb_pkg                                                      |
// | Description : Shared APB requester types and ALU register slave addresses. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } APB_STATE_e;

    localparam logic [31:0] c_ALU_REG0_ADDR = 32'h10;
    localparam logic [31:0] c_ALU_REG1_ADDR = 32'h14;
    localparam logic [31:0] c_ALU_REG2_ADDR = 32'h18;
    localparam logic [31:0] c_ALU_REG3_ADDR = 32'h1C;

    localparam int unsigned c_DEFAULT_TIMEOUT_CYC = 16;

endpackage

`default_nettype wire

// File: rtl/apb_cmd_master.sv
// +----------------------------------------------------------------------------+
// | Module      : apb_cmd_master                                               |
// | Description : Single-command valid/ready to APB requester, one response    |
// |               per command. Optional ACCESS timeout: define                 |
// |               APB_CMD_MASTER_TIMEOUT_EN.                                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module apb_cmd_master
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = c_DEFAULT_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    // The timeout counter is 8 bits wide, so the limit must fit in 1..256.
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 256) begin : g_bad_timeout
        $error("apb_cmd_master: TIMEOUT_CYC must be in 1..256");
    end

    APB_STATE_e        r_state, w_state_nxt;
    logic              r_psel, w_psel_nxt;
    logic              r_penable, w_penable_nxt;
    logic [ADDR_W-1:0] r_paddr, w_paddr_nxt;
    logic              r_pwrite, w_pwrite_nxt;
    logic [DATA_W-1:0] r_pwdata, w_pwdata_nxt;
    logic              r_rsp_valid, w_rsp_valid_nxt;
    logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
    logic              r_rsp_err, w_rsp_err_nxt;
    logic              w_tmo_hit;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
    localparam logic [7:0] c_TMO_LAST = 8'(TIMEOUT_CYC - 1);

    logic [7:0] r_tmo_cnt;

    // Counts ACCESS cycles without pready; cleared while in SETUP so it is 0 on ACCESS entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tmo_cnt <= 8'd0;
        end else if (r_state == SETUP) begin
            r_tmo_cnt <= 8'd0;
        end else if (r_state == ACCESS && !pready) begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
        end
    end

    assign w_tmo_hit = (r_tmo_cnt == c_TMO_LAST);
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_paddr     <= '0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_psel      <= w_psel_nxt;
            r_penable   <= w_penable_nxt;
            r_paddr     <= w_paddr_nxt;
            r_pwrite    <= w_pwrite_nxt;
            r_pwdata    <= w_pwdata_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_psel_nxt      = r_psel;
        w_penable_nxt   = r_penable;
        w_paddr_nxt     = r_paddr;
        w_pwrite_nxt    = r_pwrite;
        w_pwdata_nxt    = r_pwdata;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;
        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    w_paddr_nxt  = cmd_addr;
                    w_pwrite_nxt = cmd_write;
                    w_pwdata_nxt = cmd_write ? cmd_wdata : '0;
                    w_psel_nxt   = 1'b1;
                    w_state_nxt  = SETUP;
                end
            end
            SETUP: begin
                w_penable_nxt = 1'b1;
                w_state_nxt   = ACCESS;
            end
            ACCESS: begin
                // pready has priority over a timeout expiring on the same cycle.
                if (pready) begin
                    w_psel_nxt      = 1'b0;
                    w_penable_nxt   = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = r_pwrite ? '0 : prdata;
                    w_rsp_err_nxt   = 1'b0;
                    w_state_nxt     = RESP;
                end else if (w_tmo_hit) begin
                    w_psel_nxt      = 1'b0;
                    w_penable_nxt   = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = '0;
                    w_rsp_err_nxt   = 1'b1;
                    w_state_nxt     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_state_nxt     = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign cmd_ready = (r_state == IDLE);
    assign psel      = r_psel;
    assign penable   = r_penable;
    assign paddr     = r_paddr;
    assign pwrite    = r_pwrite;
    assign pwdata    = r_pwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_apb_cmd_master.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_apb_cmd_master                                            |
// | Description : Directed plus randomized bench for apb_cmd_master with a     |
// |               register-memory slave model.                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_apb_cmd_master;
    import apb_pkg::*;

    localparam int unsigned c_TMO = 4;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
    localparam bit c_TMO_EN = 1'b1;
`else
    localparam bit c_TMO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_ready = 1'b0;
    logic [31:0] prdata = '0;
    logic        pready = 1'b0;
    logic        cmd_ready, rsp_valid, rsp_err, psel, penable, pwrite;
    logic [31:0] rsp_rdata, paddr, pwdata;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int setup_cyc = 0;
    int prev_setup_cyc = 0;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] addrs [4];

    apb_cmd_master #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(c_TMO)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
        .prdata(prdata), .pready(pready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] slave_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'hA5A5_0000 ^ a;
    endfunction

    // One full command: accept, SETUP, ACCESS with `waits` wait states, response held `hold` cycles.
    task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input int waits, input int hold);
        int          n;
        int          acc;
        bit          tmo;
        logic [31:0] exp_rd;
        logic [31:0] exp_wd;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("accept_ready", 32'(cmd_ready), 32'd1);
        tick();
        setup_cyc = cyc;
        cmd_valid = 1'b0;
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        cmd_write = 1'($urandom);
        exp_wd = wr ? wd : 32'd0;
        chk("setup_psel", 32'(psel), 32'd1);
        chk("setup_penable", 32'(penable), 32'd0);
        chk("setup_paddr", paddr, addr);
        chk("setup_pwrite", 32'(pwrite), 32'(wr));
        chk("setup_pwdata", pwdata, exp_wd);
        chk("busy_cmd_ready", 32'(cmd_ready), 32'd0);
        tick();
        tmo = c_TMO_EN && (waits >= int'(c_TMO));
        acc = tmo ? int'(c_TMO) : waits + 1;
        exp_rd = 32'd0;
        for (int i = 0; i < acc; i++) begin
            chk("access_psel", 32'(psel), 32'd1);
            chk("access_penable", 32'(penable), 32'd1);
            chk("access_paddr", paddr, addr);
            chk("access_pwdata", pwdata, exp_wd);
            if (i == acc - 1) rsp_ready = (hold == 0);
            if (!tmo && i == acc - 1) begin
                pready = 1'b1;
                prdata = wr ? $urandom : slave_rd(addr);
                exp_rd = wr ? 32'd0 : prdata;
            end else begin
                pready = 1'b0;
                prdata = $urandom;
            end
            tick();
        end
        pready = 1'b0;
        prdata = $urandom;
        if (wr && !tmo) mem[addr] = wd;
        chk("resp_psel", 32'(psel), 32'd0);
        chk("resp_penable", 32'(penable), 32'd0);
        chk("resp_valid", 32'(rsp_valid), 32'd1);
        chk("resp_rdata", rsp_rdata, exp_rd);
        chk("resp_err", 32'(rsp_err), 32'(tmo));
        chk("resp_cmd_ready", 32'(cmd_ready), 32'd0);
        for (int k = 0; k < hold; k++) begin
            cmd_valid = 1'b1;
            cmd_addr  = addrs[$urandom_range(0, 3)];
            rsp_ready = 1'b0;
            tick();
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rdata", rsp_rdata, exp_rd);
            chk("hold_no_accept", 32'(psel), 32'd0);
            chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("done_valid", 32'(rsp_valid), 32'd0);
        chk("done_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("done_psel", 32'(psel), 32'd0);
    endtask

    initial begin
        addrs[0] = c_ALU_REG0_ADDR;
        addrs[1] = c_ALU_REG1_ADDR;
        addrs[2] = c_ALU_REG2_ADDR;
        addrs[3] = c_ALU_REG3_ADDR;

        #1;
        chk("rst_psel", 32'(psel), 32'd0);
        chk("rst_penable", 32'(penable), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_paddr", paddr, 32'd0);
        chk("rst_pwdata", pwdata, 32'd0);
        chk("rst_pwrite", 32'(pwrite), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        do_cmd(1'b1, 32'h10, 32'hDEADBEEF, 0, 0);
        do_cmd(1'b0, 32'h10, 32'h0, 2, 1);

        do_cmd(1'b1, 32'h14, 32'h1234_5678, 0, 0);
        prev_setup_cyc = setup_cyc;
        do_cmd(1'b0, 32'h14, 32'h0, 0, 0);
        chk("b2b_spacing", 32'(setup_cyc - prev_setup_cyc), 32'd4);

        do_cmd(1'b0, 32'h14, 32'h0, 1, 5);

        // Reset asserted in the middle of ACCESS.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = c_ALU_REG2_ADDR;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("rst_mid_penable_pre", 32'(penable), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_psel", 32'(psel), 32'd0);
        chk("rst_mid_penable", 32'(penable), 32'd0);
        chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        pready = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        pready = 1'b0;
        tick();
        chk("rst_mid_no_rsp", 32'(rsp_valid), 32'd0);
        chk("rst_mid_idle", 32'(cmd_ready), 32'd1);
        do_cmd(1'b1, c_ALU_REG2_ADDR, 32'hCAFE_F00D, 1, 0);

        // Long stall: times out when the feature is built in, completes otherwise.
        do_cmd(1'b0, c_ALU_REG3_ADDR, 32'h0, 10, 0);
        do_cmd(1'b1, c_ALU_REG3_ADDR, 32'h5555_AAAA, 3, 0);
        do_cmd(1'b0, c_ALU_REG3_ADDR, 32'h0, 0, 2);

        for (int r = 0; r < 24; r++) begin
            do_cmd(1'($urandom_range(0, 1)), addrs[$urandom_range(0, 3)], $urandom,
                   int'($urandom_range(0, 6)), int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
